// File: rtl/timer_register_bank.sv
// timer_register_bank: multi-channel two-digit-BCD countdown timer register.
// Holds a preset and a live count for each channel (ch0 = seconds, ch1 = minutes,
// ch2 = hours). The count decrements on a 1 Hz tick, borrowing from channel to
// channel. A sticky alarm flag is raised when the count reaches zero. While the
// flag is set, the VGA bus shows the preset; otherwise it shows the live count.
// Optional feature macro: TIMER_AUTO_RELOAD_EN. When it is defined, the count
// reloads from the preset at expiry and the timer keeps running.
module timer_register_bank #(
  parameter int                N_CH   = 3,
  parameter logic [N_CH*8-1:0] CH_MAX = {8'h23, 8'h59, 8'h59},
  parameter int                CH_AW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              chip_select,
  input  logic              wr_en,
  input  logic [CH_AW-1:0]  wr_ch,
  input  logic [7:0]        in_rtc_dato,
  input  logic [7:0]        in_user_dato,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  input  logic              ack_alarm,
  output logic [N_CH*8-1:0] out_dato_vga,
  output logic [7:0]        out_dato_rtc,
  output logic              running,
  output logic              flag_out
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t     state_q, state_d;
  logic [7:0] preset_q [N_CH];
  logic [7:0] preset_d [N_CH];
  logic [7:0] count_q  [N_CH];
  logic [7:0] count_d  [N_CH];
  logic [7:0] dec_val  [N_CH];
  logic       flag_q, flag_d;
  logic       dec_zero;
  logic       count_nz;
  logic       preset_nz;
  logic [7:0] wr_data;

  // Clamp an incoming value to the channel maximum. Non-BCD nibbles count as out of range.
  function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] max);
    if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > max)) return max;
    return v;
  endfunction

  // Decrement one two-digit BCD value. 00 wraps to the channel maximum.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)         return max;
    if (v[3:0] == 4'd0)     return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign wr_data = chip_select ? in_user_dato : in_rtc_dato;

  // Borrow cascade. A channel decrements only when every lower channel is at 00.
  always_comb begin : dec_cascade
    logic borrow;
    // NOTE: every variable written in always_comb gets a value before any branch; otherwise a latch is inferred.
    borrow   = 1'b1;
    dec_zero = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      dec_val[i] = borrow ? bcd_dec(count_q[i], CH_MAX[i*8 +: 8]) : count_q[i];
      borrow     = borrow & (count_q[i] == 8'h00);
      dec_zero   = dec_zero & (dec_val[i] == 8'h00);
    end
  end

  // Reduce the count and the preset to "any channel non-zero" flags.
  always_comb begin
    count_nz  = 1'b0;
    preset_nz = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      count_nz  = count_nz  | (count_q[i]  != 8'h00);
      preset_nz = preset_nz | (preset_q[i] != 8'h00);
    end
  end

  // Next-state and datapath update. A write, a decrement or a reload is selected by state.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    flag_d   = flag_q;

`ifdef TIMER_AUTO_RELOAD_EN
    // With auto-reload, the acknowledge clears only the flag and works in any state.
    if (ack_alarm) flag_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (wr_en && !hold) begin
          for (int i = 0; i < N_CH; i++) begin
            if (wr_ch == CH_AW'(i)) begin
              preset_d[i] = sanitize(wr_data, CH_MAX[i*8 +: 8]);
              count_d[i]  = sanitize(wr_data, CH_MAX[i*8 +: 8]);
            end
          end
        end
        if (start && count_nz) state_d = RUN;
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick && !hold) begin
          if (dec_zero) begin
            flag_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            count_d = preset_q;
            if (!preset_nz) state_d = IDLE;
`else
            count_d = dec_val;
            state_d = EXPIRED;
`endif
          end else begin
            count_d = dec_val;
          end
        end
      end

      EXPIRED: begin
        if (ack_alarm) begin
          flag_d  = 1'b0;
          count_d = preset_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, preset, count and flag registers. The reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q <= IDLE;
      flag_q  <= 1'b0;
      // NOTE: these are small flop arrays, not a RAM, so each entry is reset explicitly.
      for (int i = 0; i < N_CH; i++) begin
        preset_q[i] <= 8'h00;
        count_q[i]  <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // Display bus and preset readback, decoded from the registers.
  always_comb begin
    out_dato_rtc = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      out_dato_vga[i*8 +: 8] = flag_q ? preset_q[i] : count_q[i];
      if (wr_ch == CH_AW'(i)) out_dato_rtc = preset_q[i];
    end
  end

  assign running  = (state_q == RUN);
  assign flag_out = flag_q;

endmodule

// File: tb/tb_timer_register_bank.sv
// Self-checking bench for timer_register_bank. Write vectors are table-driven.
// Countdown, gating, expiry and reset corners are hand-written sequences.
// Expectations follow TIMER_AUTO_RELOAD_EN when that macro is defined.
module tb_timer_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        chip_select;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [7:0]  in_rtc_dato;
  logic [7:0]  in_user_dato;
  logic        start;
  logic        stop;
  logic        tick;
  logic        ack_alarm;
  logic [23:0] out_dato_vga;
  logic [7:0]  out_dato_rtc;
  logic        running;
  logic        flag_out;

  int n_checks = 0;
  int n_passed = 0;

  timer_register_bank dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .chip_select  (chip_select),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .in_rtc_dato  (in_rtc_dato),
    .in_user_dato (in_user_dato),
    .start        (start),
    .stop         (stop),
    .tick         (tick),
    .ack_alarm    (ack_alarm),
    .out_dato_vga (out_dato_vga),
    .out_dato_rtc (out_dato_rtc),
    .running      (running),
    .flag_out     (flag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic        sel;
    logic        hold;
    logic [7:0]  rtc;
    logic [7:0]  user;
    logic [7:0]  exp_rtc;
    logic [23:0] exp_vga;
  } wr_vec_t;

  wr_vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_passed++;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] v);
    chip_select  = 1'b1;
    in_user_dato = v;
    wr_ch        = ch;
    wr_en        = 1'b1;
    cycle();
    wr_en        = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; chip_select = 1'b0; wr_en = 1'b0; wr_ch = 2'd0;
    in_rtc_dato = 8'h00; in_user_dato = 8'h00;
    start = 1'b0; stop = 1'b0; tick = 1'b0; ack_alarm = 1'b0;

    //               ch    sel   hold  rtc    user   rtc_rb vga
    vecs[0] = '{2'd0, 1'b1, 1'b0, 8'h00, 8'h75, 8'h59, 24'h000059};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 8'h42, 8'h11, 8'h42, 24'h000042};
    vecs[2] = '{2'd1, 1'b1, 1'b0, 8'h12, 8'h3A, 8'h59, 24'h005942};
    vecs[3] = '{2'd2, 1'b0, 1'b0, 8'h24, 8'h05, 8'h23, 24'h235942};
    vecs[4] = '{2'd2, 1'b0, 1'b0, 8'h19, 8'h22, 8'h19, 24'h195942};
    vecs[5] = '{2'd1, 1'b1, 1'b0, 8'h45, 8'h00, 8'h00, 24'h190042};
    vecs[6] = '{2'd3, 1'b1, 1'b0, 8'h33, 8'h11, 8'h00, 24'h190042};
    vecs[7] = '{2'd1, 1'b0, 1'b0, 8'hF0, 8'h07, 8'h59, 24'h195942};
    vecs[8] = '{2'd0, 1'b1, 1'b1, 8'h01, 8'h30, 8'h42, 24'h195942};

    // Reset state, with start and tick asserted to show that reset overrides them.
    start = 1'b1; tick = 1'b1;
    cycle(); cycle();
    check("rst_vga", 32'(out_dato_vga), 32'h0);
    check("rst_rtc", 32'(out_dato_rtc), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_flag", 32'(flag_out), 32'h0);
    start = 1'b0; tick = 1'b0; reset = 1'b0;
    cycle();

    // Table-driven writes: source select, clamping, invalid channel, hold blocking.
    for (int i = 0; i < 9; i++) begin
      wr_ch        = vecs[i].ch;
      chip_select  = vecs[i].sel;
      hold         = vecs[i].hold;
      in_rtc_dato  = vecs[i].rtc;
      in_user_dato = vecs[i].user;
      wr_en        = 1'b1;
      cycle();
      wr_en        = 1'b0;
      hold         = 1'b0;
      check($sformatf("wr%0d_rtc", i), 32'(out_dato_rtc), 32'(vecs[i].exp_rtc));
      check($sformatf("wr%0d_vga", i), 32'(out_dato_vga), 32'(vecs[i].exp_vga));
    end

    // Borrow across all channels: 01:00:00 goes to 00:59:59 on one tick.
    wr(2'd2, 8'h01); wr(2'd1, 8'h00); wr(2'd0, 8'h00);
    pulse_start();
    check("borrow_start_running", 32'(running), 32'h1);
    check("borrow_start_vga", 32'(out_dato_vga), 32'h010000);
    pulse_tick();
    check("borrow_vga", 32'(out_dato_vga), 32'h005959);
    check("borrow_running", 32'(running), 32'h1);

    // Hold freezes counting for three ticks.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      cycle();
    end
    hold = 1'b0;
    check("hold_vga", 32'(out_dato_vga), 32'h005959);
    check("hold_running", 32'(running), 32'h1);

    // Stop beats start and tick in the same cycle.
    stop = 1'b1; start = 1'b1; tick = 1'b1;
    cycle();
    stop = 1'b0; start = 1'b0; tick = 1'b0;
    check("stop_running", 32'(running), 32'h0);
    check("stop_vga", 32'(out_dato_vga), 32'h005959);

    // Start with a zero count stays idle.
    wr(2'd0, 8'h00); wr(2'd1, 8'h00); wr(2'd2, 8'h00);
    check("zero_vga", 32'(out_dato_vga), 32'h0);
    pulse_start();
    check("zero_start_running", 32'(running), 32'h0);

    // Expiry from 00:00:02.
    wr(2'd0, 8'h02);
    pulse_start();
    check("exp_running", 32'(running), 32'h1);
    pulse_tick();
    check("exp_tick1_vga", 32'(out_dato_vga), 32'h000001);
    check("exp_tick1_flag", 32'(flag_out), 32'h0);
    pulse_tick();
    check("exp_tick2_flag", 32'(flag_out), 32'h1);
    check("exp_tick2_vga", 32'(out_dato_vga), 32'h000002);
`ifdef TIMER_AUTO_RELOAD_EN
    check("exp_tick2_running", 32'(running), 32'h1);
`else
    check("exp_tick2_running", 32'(running), 32'h0);
    // Further ticks while expired leave the flag and the display unchanged.
    pulse_tick();
    check("exp_hold_flag", 32'(flag_out), 32'h1);
    check("exp_hold_vga", 32'(out_dato_vga), 32'h000002);
`endif
    // Acknowledge together with start.
    ack_alarm = 1'b1; start = 1'b1;
    cycle();
    ack_alarm = 1'b0; start = 1'b0;
    check("ack_flag", 32'(flag_out), 32'h0);
    check("ack_vga", 32'(out_dato_vga), 32'h000002);
`ifdef TIMER_AUTO_RELOAD_EN
    check("ack_running", 32'(running), 32'h1);
    pulse_tick();
    check("reload_tick_vga", 32'(out_dato_vga), 32'h000001);
    stop = 1'b1; cycle(); stop = 1'b0;

    // Auto-reload from preset 00:00:03.
    wr(2'd0, 8'h03);
    pulse_start();
    for (int i = 0; i < 3; i++) pulse_tick();
    check("ar_flag", 32'(flag_out), 32'h1);
    check("ar_running", 32'(running), 32'h1);
    check("ar_vga", 32'(out_dato_vga), 32'h000003);
    ack_alarm = 1'b1; cycle(); ack_alarm = 1'b0;
    check("ar_ack_vga", 32'(out_dato_vga), 32'h000003);
    pulse_tick();
    check("ar_next_vga", 32'(out_dato_vga), 32'h000002);
    stop = 1'b1; cycle(); stop = 1'b0;
`else
    check("ack_running", 32'(running), 32'h0);
    pulse_start();
    check("restart_running", 32'(running), 32'h1);
    stop = 1'b1; cycle(); stop = 1'b0;
`endif

    // Reset in the middle of a run at 00:10:05, with a tick asserted alongside it.
    wr(2'd2, 8'h00); wr(2'd1, 8'h10); wr(2'd0, 8'h05);
    pulse_start();
    pulse_tick();
    check("mid_vga", 32'(out_dato_vga), 32'h001004);
    wr_ch = 2'd1;
    reset = 1'b1; tick = 1'b1;
    cycle();
    reset = 1'b0; tick = 1'b0;
    check("mid_rst_vga", 32'(out_dato_vga), 32'h0);
    check("mid_rst_running", 32'(running), 32'h0);
    check("mid_rst_flag", 32'(flag_out), 32'h0);
    check("mid_rst_rtc", 32'(out_dato_rtc), 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
